// File: rtl/counter_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// counter_arbiter_pkg
//   Shared definitions for the counter arbiter slice: FSM state encoding and
//   default parameter values used by counter_arbiter and cnt_core.
//   No ports (package).
// -----------------------------------------------------------------------------
package counter_arbiter_pkg;

    // Default number of requesters and counter width.
    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 3;

    // Arbiter FSM. The fourth 2-bit code is unreachable and decodes to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : counter_arbiter_pkg

// File: rtl/counter_arbiter_cnt_core.sv
// -----------------------------------------------------------------------------
// cnt_core
//   Shared job counter. Clears to zero, otherwise increments by one per enabled
//   cycle and saturates at the terminal value, so it never wraps.
//
//   Ports
//     clk      in   rising-edge clock
//     reset    in   synchronous active-high reset
//     clear    in   force count to zero on the next edge
//     enable   in   count this cycle (ignored once the count equals term)
//     term     in   [CW-1:0] terminal count for the current job
//     cnt      out  [CW-1:0] current count
//     at_term  out  cnt == term
// -----------------------------------------------------------------------------
module cnt_core
    import counter_arbiter_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] cnt,
    output logic          at_term
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    assign at_term = (cnt_q == term);
    assign cnt     = cnt_q;

    // NOTE: every always_comb output gets a default on the first line so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !at_term) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: registers are written only with non-blocking assignments so every
    // flop samples the values that existed before this clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : cnt_core

// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
//   Round-robin arbiter that hands a shared counter to one requester at a time.
//   The winner owns the counter from 0 up to its own terminal count, then gets
//   a one-cycle done pulse. Dropping the request mid-job abandons it silently.
//
//   Ports
//     clk    in   rising-edge clock
//     reset  in   synchronous active-high reset (overrides everything)
//     req    in   [NREQ-1:0]    level requests
//     len    in   [NREQ*CW-1:0] terminal counts, slice i at [i*CW +: CW]
//     gnt    out  [NREQ-1:0]    one-hot owner grant while in RUN
//     busy   out  state is not IDLE
//     cnt    out  [CW-1:0]      shared counter value
//     done   out  [NREQ-1:0]    one-hot completion pulse while in DONE
// -----------------------------------------------------------------------------
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [CW-1:0]      cnt,
    output logic [NREQ-1:0]    done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e        state_d, state_q;
    logic [IW-1:0] owner_d, owner_q;
    logic [IW-1:0] ptr_d,   ptr_q;
    logic [CW-1:0] term_d,  term_q;

    logic          cnt_clear;
    logic          cnt_enable;
    logic          at_term;
    logic          owner_req;

    // Round-robin search results.
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    int            cand;
    logic [IW-1:0] cand_idx;

    assign owner_req = req[owner_q];

    // ------------------------------------------------------------------------
    // Round-robin pick: scan from the requester after the last winner and
    // wrap, so the previous owner is considered last.
    // ------------------------------------------------------------------------
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(ptr_q) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Job FSM. Owner and terminal count are latched once at job start, so
    // later changes to len or to other requesters cannot disturb the job.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        term_d  = term_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = RUN;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    term_d  = len[int'(pick_idx)*CW +: CW];
                end
            end
            RUN: begin
                // Abandon is tested first so it wins over a same-cycle match.
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (at_term) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter control: zero in IDLE (so a new job starts from 0), on abandon,
    // and on leaving DONE; count only while the owner still requests.
    always_comb begin
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            IDLE:    cnt_clear  = 1'b1;
            RUN:     begin
                cnt_clear  = !owner_req;
                cnt_enable = owner_req;
            end
            DONE:    cnt_clear  = 1'b1;
            default: cnt_clear  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            // Pointer parks on the last requester so requester 0 wins first.
            ptr_q   <= IW'(NREQ - 1);
            term_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            term_q  <= term_d;
        end
    end

    cnt_core #(
        .CW (CW)
    ) u_cnt_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .term    (term_q),
        .cnt     (cnt),
        .at_term (at_term)
    );

    // ------------------------------------------------------------------------
    // Outputs decode straight from registered state, so gnt and done are
    // mutually exclusive and each at most one-hot.
    // ------------------------------------------------------------------------
    always_comb begin
        gnt  = '0;
        done = '0;
        if (state_q == RUN) begin
            gnt[owner_q] = 1'b1;
        end
        if (state_q == DONE) begin
            done[owner_q] = 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

endmodule : counter_arbiter

// File: tb/tb_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_arbiter
//   Directed bench for counter_arbiter (NREQ=4, CW=3). Inputs change and
//   outputs are sampled on the falling edge, half a cycle from the active edge.
// -----------------------------------------------------------------------------
module tb_counter_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 3;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [CW-1:0]      cnt;
    logic [NREQ-1:0]    done;

    int checks   = 0;
    int failures = 0;

    counter_arbiter #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .busy  (busy),
        .cnt   (cnt),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        len   = {3'd7, 3'd7, 3'd7, 3'd7};
        @(negedge clk);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        req   = '0;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_hold_busy: got %b want 0", busy); end
    endtask

    // req0 alone, len0=3: four grant cycles counting 0..3, then done.
    task automatic test_single();
        apply_reset();
        req = 4'b0001;
        len = {3'd6, 3'd5, 3'd4, 3'd3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt[%0d]: got %b want 0001", i, gnt); end
            checks++; if (cnt !== 3'(i)) begin failures++; $display("FAIL single_cnt[%0d]: got %0d want %0d", i, cnt, i); end
            checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_early_done[%0d]: got %b want 0000", i, done); end
        end
        @(negedge clk);
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL single_done: got %b want 0001", done); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_in_done: got %b want 0000", gnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_in_done: got %b want 1", busy); end
        req = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b want 0", busy); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_done_width: got %b want 0000", done); end
        checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL single_cnt_after: got %0d want 0", cnt); end
    endtask

    // All four requesting with len=1: grants rotate 0,1,2,3,0 with one idle
    // cycle between each done pulse and the next grant.
    task automatic test_round_robin();
        logic [NREQ-1:0] exp_oh;
        apply_reset();
        req = 4'b1111;
        len = {3'd1, 3'd1, 3'd1, 3'd1};
        for (int j = 0; j < 5; j++) begin
            exp_oh = 4'b0001 << (j % 4);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                checks++; if (gnt !== exp_oh) begin failures++; $display("FAIL rr_gnt[job%0d,c%0d]: got %b want %b", j, c, gnt, exp_oh); end
                checks++; if (cnt !== 3'(c)) begin failures++; $display("FAIL rr_cnt[job%0d,c%0d]: got %0d want %0d", j, c, cnt, c); end
            end
            @(negedge clk);
            checks++; if (done !== exp_oh) begin failures++; $display("FAIL rr_done[job%0d]: got %b want %b", j, done, exp_oh); end
            if (j == 4) req = '0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL rr_gap[job%0d]: busy=%b gnt=%b want busy=0 gnt=0000", j, busy, gnt); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_final_idle: got %b want 0", busy); end
    endtask

    // len=0 gives exactly one grant cycle with cnt=0.
    task automatic test_zero_len();
        apply_reset();
        req = 4'b0100;
        len = {3'd7, 3'd0, 3'd7, 3'd7};
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL zero_gnt: got %b want 0100", gnt); end
        checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL zero_cnt: got %0d want 0", cnt); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL zero_gnt2: got %b want 0000", gnt); end
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL zero_done: got %b want 0100", done); end
        req = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_idle: got %b want 0", busy); end
    endtask

    // Drop req1 at cnt=2; ptr stays 1 so req0|req1 next grants 0. Then drop
    // req0 exactly at its terminal count: abandon wins, no done pulse.
    task automatic test_abandon();
        apply_reset();
        req = 4'b0010;
        len = {3'd0, 3'd0, 3'd5, 3'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (gnt !== 4'b0010 || cnt !== 3'(i)) begin failures++; $display("FAIL abandon_run[%0d]: gnt=%b cnt=%0d want gnt=0010 cnt=%0d", i, gnt, cnt, i); end
        end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abandon_busy: got %b want 0", busy); end
        checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL abandon_cnt: got %0d want 0", cnt); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL abandon_done: got %b want 0000", done); end
        req = 4'b0011;
        len = {3'd0, 3'd0, 3'd5, 3'd1};
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL abandon_next_owner: got %b want 0001", gnt); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0001 || cnt !== 3'd1) begin failures++; $display("FAIL abandon_at_term: gnt=%b cnt=%0d want gnt=0001 cnt=1", gnt, cnt); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL abandon_priority_done: got %b want 0000", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abandon_priority_busy: got %b want 0", busy); end
    endtask

    // len0=7 counts to the max without wrap; rewriting len0 mid-job and
    // toggling other requesters must not matter.
    task automatic test_max_len();
        apply_reset();
        req = 4'b0001;
        len = {3'd0, 3'd0, 3'd0, 3'd7};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (gnt !== 4'b0001 || cnt !== 3'(i)) begin failures++; $display("FAIL max_run[%0d]: gnt=%b cnt=%0d want gnt=0001 cnt=%0d", i, gnt, cnt, i); end
            if (i == 3) begin
                len = {3'd0, 3'd0, 3'd0, 3'd2};
                req = 4'b1011;
            end
        end
        @(negedge clk);
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL max_done: got %b want 0001", done); end
        checks++; if (cnt !== 3'd7) begin failures++; $display("FAIL max_cnt_hold: got %0d want 7", cnt); end
        req = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || cnt !== 3'd0) begin failures++; $display("FAIL max_idle: busy=%b cnt=%0d want busy=0 cnt=0", busy, cnt); end
    endtask

    // Reset while counting at cnt=4 aborts the job with no done pulse.
    task automatic test_reset_mid_run();
        apply_reset();
        req = 4'b0001;
        len = {3'd0, 3'd0, 3'd0, 3'd6};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
        end
        checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL midrst_pre_cnt: got %0d want 4", cnt); end
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || cnt !== 3'd0) begin
            failures++;
            $display("FAIL midrst_outputs: gnt=%b done=%b busy=%b cnt=%0d want all zero", gnt, done, busy, cnt);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (done !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL midrst_after: done=%b busy=%b want 0000/0", done, busy); end
        // Pointer back at NREQ-1: requester 0 beats 3.
        req = 4'b1001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_ptr: got %b want 0001", gnt); end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        len   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_abandon();
        test_max_len();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_counter_arbiter
